// File: rtl/serial_seq_detector.sv
// serial_seq_detector
//   Watches the registered serial stream from the upstream flip-flop stage and
//   flags every occurrence of PATTERN. Matches may overlap. Each match produces
//   a one-cycle registered pulse and bumps a saturating match counter.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   en           sample enable, din is accepted only while en is high
//   clr          synchronous clear of history, fill state and counter (beats en)
//   din          serial data bit from the upstream flip-flop
//   armed        high once PAT_LEN bits have been accepted since reset/clr
//   match        one-cycle pulse, last PAT_LEN accepted bits equal PATTERN
//   match_count  matches since reset/clr, saturates at all-ones
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FILL  | fewer than PAT_LEN bits accepted, history not yet trustworthy
// S_ARMED | PAT_LEN or more bits accepted, every new bit can complete a match

module serial_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    // One spare bit of headroom so fill+1 never wraps for any legal PAT_LEN.
    localparam int FW = $clog2(PAT_LEN + 2);

    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_ARMED = 1'b1;

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] next_hist;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_inc;
    logic               fill_done;
    logic               hit;
    logic [0:0]         state;

    assign next_hist = {hist[PAT_LEN-2:0], din};
    assign fill_inc  = fill + 1'b1;
    assign fill_done = (fill_inc >= FILL_MAX);
    // The fill qualifier keeps the reset-zero history from producing a match
    // before PAT_LEN real bits have arrived (matters for all-zero patterns).
    assign hit       = (next_hist == PATTERN) && fill_done;

    assign armed = (state == S_ARMED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist        <= '0;
            fill        <= '0;
            state       <= S_FILL;
            match       <= 1'b0;
            match_count <= '0;
        end else if (clr) begin
            hist        <= '0;
            fill        <= '0;
            state       <= S_FILL;
            match       <= 1'b0;
            match_count <= '0;
        end else if (en) begin
            hist  <= next_hist;
            fill  <= fill_done ? FILL_MAX : fill_inc;
            if (fill_done) begin
                state <= S_ARMED;
            end
            match <= hit;
            if (hit && (match_count != CNT_MAX)) begin
                match_count <= match_count + 1'b1;
            end
        end else begin
            match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_seq_detector.sv
// Testbench for serial_seq_detector. Three instances share one stimulus
// stream: default 1011/8-bit counter, an all-zero pattern, and 1111 with a
// 2-bit counter. A reference model keeps the accepted bit stream as a queue
// and derives armed/match/count directly from it.

module tb_serial_seq_detector;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       din;

    logic       armed_a, armed_b, armed_c;
    logic       match_a, match_b, match_c;
    logic [7:0] mc_a, mc_b;
    logic [1:0] mc_c;

    serial_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din),
        .armed(armed_a), .match(match_a), .match_count(mc_a)
    );

    serial_seq_detector #(.PAT_LEN(4), .PATTERN(4'b0000), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din),
        .armed(armed_b), .match(match_b), .match_count(mc_b)
    );

    serial_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din),
        .armed(armed_c), .match(match_c), .match_count(mc_c)
    );

    logic       obs_armed [3];
    logic       obs_match [3];
    logic [7:0] obs_cnt   [3];

    assign obs_armed[0] = armed_a;
    assign obs_armed[1] = armed_b;
    assign obs_armed[2] = armed_c;
    assign obs_match[0] = match_a;
    assign obs_match[1] = match_b;
    assign obs_match[2] = match_c;
    assign obs_cnt[0]   = mc_a;
    assign obs_cnt[1]   = mc_b;
    assign obs_cnt[2]   = {6'b0, mc_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model
    bit         acc_q [$];
    bit         exp_armed;
    bit         exp_match [3];
    logic [7:0] exp_cnt   [3];
    int         pat       [3] = '{'b1011, 'b0000, 'b1111};
    int         cmax      [3] = '{255, 255, 3};

    function automatic void model_clear();
        acc_q.delete();
        exp_armed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_match[k] = 1'b0;
            exp_cnt[k]   = 8'd0;
        end
    endfunction

    function automatic void model_step(input bit e, input bit c, input bit d);
        int last4;
        if (c) begin
            model_clear();
        end else if (e) begin
            acc_q.push_back(d);
            if (acc_q.size() > 4) void'(acc_q.pop_front());
            last4 = 0;
            foreach (acc_q[j]) last4 = last4 * 2 + int'(acc_q[j]);
            exp_armed = (acc_q.size() >= 4);
            for (int k = 0; k < 3; k++) begin
                exp_match[k] = exp_armed && (last4 == pat[k]);
                if (exp_match[k] && int'(exp_cnt[k]) < cmax[k]) exp_cnt[k] = exp_cnt[k] + 8'd1;
            end
        end else begin
            for (int k = 0; k < 3; k++) exp_match[k] = 1'b0;
        end
    endfunction

    task automatic apply_edge(input bit e, input bit c, input bit d);
        en  = e;
        clr = c;
        din = d;
        @(posedge clk);
        model_step(e, c, d);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        clr = 1'b0;
        din = 1'b0;
        model_clear();
        #12;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_armed[k] !== 1'b0 || obs_match[k] !== 1'b0 || obs_cnt[k] !== 8'd0) begin
                miscompares++;
                $display("FAIL reset inst%0d: got armed=%b match=%b cnt=%0d, want 0/0/0",
                         k, obs_armed[k], obs_match[k], obs_cnt[k]);
            end
        end
        rst = 1'b1;
        #5;
    endtask

    task automatic test_overlap();
        bit seq [7] = '{1, 0, 1, 1, 0, 1, 1};
        apply_edge(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            apply_edge(1'b1, 1'b0, seq[i]);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_armed[k] !== exp_armed || obs_match[k] !== exp_match[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    miscompares++;
                    $display("FAIL overlap bit%0d inst%0d: got %b/%b/%0d want %b/%b/%0d", i + 1, k,
                             obs_armed[k], obs_match[k], obs_cnt[k], exp_armed, exp_match[k], exp_cnt[k]);
                end
            end
            vectors++;
            if (match_a !== (i == 3 || i == 6) || armed_a !== (i >= 3)) begin
                miscompares++;
                $display("FAIL overlap_1011 bit%0d: got match=%b armed=%b want match=%b armed=%b",
                         i + 1, match_a, armed_a, (i == 3 || i == 6), (i >= 3));
            end
        end
        vectors++;
        if (mc_a !== 8'd2) begin
            miscompares++;
            $display("FAIL overlap_count: got %0d want 2", mc_a);
        end
    endtask

    task automatic test_zero_pattern();
        apply_edge(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            apply_edge(1'b1, 1'b0, 1'b0);
            vectors++;
            if (match_b !== (i >= 3) || mc_b !== ((i >= 3) ? 8'(i - 2) : 8'd0)) begin
                miscompares++;
                $display("FAIL zero_pattern bit%0d: got match=%b cnt=%0d want match=%b cnt=%0d",
                         i + 1, match_b, mc_b, (i >= 3), (i >= 3) ? i - 2 : 0);
            end
        end
    endtask

    task automatic test_saturation();
        apply_edge(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply_edge(1'b1, 1'b0, 1'b1);
            vectors++;
            if (match_c !== (i >= 3) || mc_c !== ((i < 3) ? 2'd0 : (i == 3) ? 2'd1 : (i == 4) ? 2'd2 : 2'd3)) begin
                miscompares++;
                $display("FAIL saturation cycle%0d: got match=%b cnt=%0d", i + 1, match_c, mc_c);
            end
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_armed[k] !== exp_armed || obs_match[k] !== exp_match[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    miscompares++;
                    $display("FAIL saturation_model cycle%0d inst%0d: got %b/%b/%0d want %b/%b/%0d", i + 1, k,
                             obs_armed[k], obs_match[k], obs_cnt[k], exp_armed, exp_match[k], exp_cnt[k]);
                end
            end
        end
    endtask

    task automatic test_gap();
        bit pre [3] = '{1, 0, 1};
        apply_edge(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply_edge(1'b1, 1'b0, pre[i]);
        for (int i = 0; i < 5; i++) begin
            apply_edge(1'b0, 1'b0, i[0]);
            vectors++;
            if (match_a !== 1'b0 || armed_a !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_hold cycle%0d: got match=%b armed=%b want 0/0", i, match_a, armed_a);
            end
        end
        apply_edge(1'b1, 1'b0, 1'b1);
        vectors++;
        if (match_a !== 1'b1 || mc_a !== 8'd1 || armed_a !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_resume: got match=%b cnt=%0d armed=%b want 1/1/1", match_a, mc_a, armed_a);
        end
        apply_edge(1'b0, 1'b0, 1'b1);
        vectors++;
        if (match_a !== 1'b0 || mc_a !== 8'd1) begin
            miscompares++;
            $display("FAIL gap_pulse_width: got match=%b cnt=%0d want 0/1", match_a, mc_a);
        end
    endtask

    task automatic test_clr();
        bit pre  [3] = '{1, 0, 1};
        bit post [5] = '{1, 1, 0, 1, 1};
        for (int i = 0; i < 3; i++) apply_edge(1'b1, 1'b0, pre[i]);
        apply_edge(1'b1, 1'b1, 1'b1);
        vectors++;
        if (armed_a !== 1'b0 || match_a !== 1'b0 || mc_a !== 8'd0) begin
            miscompares++;
            $display("FAIL clr_state: got armed=%b match=%b cnt=%0d want 0/0/0", armed_a, match_a, mc_a);
        end
        for (int i = 0; i < 5; i++) begin
            apply_edge(1'b1, 1'b0, post[i]);
            vectors++;
            if (match_a !== (i == 4) || armed_a !== (i >= 3)) begin
                miscompares++;
                $display("FAIL clr_refill bit%0d: got match=%b armed=%b want %b/%b",
                         i + 1, match_a, armed_a, (i == 4), (i >= 3));
            end
        end
    endtask

    task automatic test_async_reset();
        bit pre  [3] = '{1, 0, 1};
        bit post [5] = '{1, 1, 0, 1, 1};
        apply_edge(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) apply_edge(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) apply_edge(1'b1, 1'b0, pre[i]);
        #3;
        rst = 1'b0;
        model_clear();
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_armed[k] !== 1'b0 || obs_match[k] !== 1'b0 || obs_cnt[k] !== 8'd0) begin
                miscompares++;
                $display("FAIL async_reset inst%0d: got %b/%b/%0d want 0/0/0",
                         k, obs_armed[k], obs_match[k], obs_cnt[k]);
            end
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            apply_edge(1'b1, 1'b0, post[i]);
            vectors++;
            if (match_a !== (i == 4) || mc_a !== ((i == 4) ? 8'd1 : 8'd0)) begin
                miscompares++;
                $display("FAIL async_refill bit%0d: got match=%b cnt=%0d want %b/%0d",
                         i + 1, match_a, mc_a, (i == 4), (i == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_random();
        bit e, c, d;
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(3, 0) != 0);
            c = ($urandom_range(47, 0) == 0);
            d = ($urandom_range(99, 0) < 70);
            apply_edge(e, c, d);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_armed[k] !== exp_armed || obs_match[k] !== exp_match[k] || obs_cnt[k] !== exp_cnt[k]) begin
                    miscompares++;
                    $display("FAIL random step%0d inst%0d: got %b/%b/%0d want %b/%b/%0d", i, k,
                             obs_armed[k], obs_match[k], obs_cnt[k], exp_armed, exp_match[k], exp_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_zero_pattern();
        test_saturation();
        test_gap();
        test_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
